// File: rtl/mul_acc_pkg.sv
// Shared types and default parameters for the product accumulator.
package mul_acc_pkg;

  typedef enum logic {ACCUM, HOLD} mul_acc_state_t;

  localparam int N_DEF     = 8;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mul_product_accumulator_sat_add.sv
// Combinational w-bit saturating adder, signed or unsigned per is_signed.
module sat_add #(
  parameter int w = 32
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  input  logic         is_signed,
  output logic [w-1:0] sum,
  output logic         ovf
);

  logic [w:0]   ext;
  logic [w-1:0] pos_max;
  logic [w-1:0] neg_min;

  always_comb begin
    ext     = {1'b0, a} + {1'b0, b};
    pos_max = {1'b0, {(w-1){1'b1}}};
    neg_min = {1'b1, {(w-1){1'b0}}};
    sum     = ext[w-1:0];
    ovf     = 1'b0;
    if (is_signed) begin
      // overflow only when both operands agree in sign and the result does not
      if ((a[w-1] == b[w-1]) && (ext[w-1] != a[w-1])) begin
        ovf = 1'b1;
        sum = a[w-1] ? neg_min : pos_max;
      end
    end else if (ext[w]) begin
      ovf = 1'b1;
      sum = {w{1'b1}};
    end
  end

endmodule

// File: rtl/mul_product_accumulator.sv
// Accumulates a packet of signed/unsigned products into a saturating sum and
// presents sum, sticky overflow and beat count on a registered valid/ready port.
//
//   state | meaning
//   ACCUM | accepting product beats, accumulating the current packet
//   HOLD  | packet result presented, waiting for down_ready
module mul_product_accumulator
  import mul_acc_pkg::*;
#(
  parameter int n     = N_DEF,
  parameter int acc_w = ACC_W_DEF,
  parameter int cnt_w = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [2*n-1:0]   up_product,
  input  logic             up_signed,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [acc_w-1:0] down_sum,
  output logic             down_overflow,
  output logic [cnt_w-1:0] down_count
);

  mul_acc_state_t   state_q, state_d;
  logic [acc_w-1:0] acc_q, acc_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;
  logic             first_q, first_d;
  logic             dv_d;
  logic [acc_w-1:0] ds_d;
  logic             dovf_d;
  logic [cnt_w-1:0] dcnt_d;

  logic             beat;
  logic             xfer;
  logic             mode_eff;
  logic [acc_w-1:0] prod_ext;
  logic [acc_w-1:0] add_sum;
  logic             add_ovf;
  logic             ovf_next;
  logic [cnt_w-1:0] cnt_next;

  assign up_ready = (state_q == ACCUM);
  assign beat     = up_valid & up_ready;
  assign xfer     = down_valid & down_ready;
  // mode is taken live from up_signed on the first beat, latched afterwards
  assign mode_eff = first_q ? up_signed : mode_q;
  assign prod_ext = {{(acc_w-2*n){up_product[2*n-1] & mode_eff}}, up_product};
  assign ovf_next = ovf_q | add_ovf;
  assign cnt_next = (cnt_q == {cnt_w{1'b1}}) ? cnt_q : cnt_q + cnt_w'(1);

  sat_add #(.w(acc_w)) u_sat_add (
    .a         (acc_q),
    .b         (prod_ext),
    .is_signed (mode_eff),
    .sum       (add_sum),
    .ovf       (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    first_d = first_q;
    dv_d    = down_valid;
    ds_d    = down_sum;
    dovf_d  = down_overflow;
    dcnt_d  = down_count;
    case (state_q)
      ACCUM: begin
        if (beat) begin
          if (up_last) begin
            ds_d    = add_sum;
            dovf_d  = ovf_next;
            dcnt_d  = cnt_next;
            dv_d    = 1'b1;
            state_d = HOLD;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            mode_d  = 1'b0;
            first_d = 1'b1;
          end else begin
            acc_d   = add_sum;
            cnt_d   = cnt_next;
            ovf_d   = ovf_next;
            mode_d  = mode_eff;
            first_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (xfer) begin
          dv_d    = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACCUM;
      acc_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      mode_q        <= 1'b0;
      first_q       <= 1'b1;
      down_valid    <= 1'b0;
      down_sum      <= '0;
      down_overflow <= 1'b0;
      down_count    <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      mode_q        <= mode_d;
      first_q       <= first_d;
      down_valid    <= dv_d;
      down_sum      <= ds_d;
      down_overflow <= dovf_d;
      down_count    <= dcnt_d;
    end
  end

endmodule
